// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive framing path.
// Used by rx_frame_module and rx_bps_module; the RX_TIMEOUT_EN build option
// of rx_frame_module draws its idle-line limit from RX_TIMEOUT_BITS here.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    START,
    DATA,
    STOP,
    DONE
  } rx_state_t;

  localparam int RX_MAX_BYTES    = 16;
  localparam int RX_TIMEOUT_BITS = 16;

  // Clock cycles per serial bit period.
  function automatic int bit_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/rx_bps_module.sv
// Restartable bit-period tick generator for the UART receiver.
// Latency: tick is combinational from the counter; clr restarts the count next cycle.
// Backpressure: none; counts whenever en is high and clr is low.
module rx_bps_module #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic half,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] MID  = CW'(DIV / 2 - 1);

  logic [CW-1:0] cnt;

  // Free-running modulo-DIV counter, restarted to zero by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Mid-bit tick when half is set, end-of-bit tick otherwise.
  assign tick = en && (cnt == (half ? MID : LAST));

endmodule

// File: rtl/rx_frame_module.sv
// UART 8N1 receive framing: packs len bytes into a 128-bit word, first byte in the top lane.
// Latency: rx_done BIT_DIV/2 + 9*BIT_DIV + 2 cycles after the synchronised final start edge.
// Backpressure: none; rx_en while busy is dropped. Optional macro RX_TIMEOUT_EN adds an idle-line timeout.
module rx_frame_module
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int MAX_BYTES = RX_MAX_BYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx_pin_in,
  input  logic         rx_en,
  input  logic [4:0]   len,
  output logic [127:0] rx_data,
  output logic         rx_done,
  output logic         rx_err,
  output logic         rx_busy
);

  localparam int BIT_DIV = bit_div(CLK_HZ, BAUD);
  localparam logic [4:0] MAX_LEN = 5'(MAX_BYTES);

  rx_state_t state, state_nxt;

  logic       sync1, rxs;
  logic [4:0] cnt;
  logic [3:0] bitcnt;
  logic [7:0] shreg;
  logic [3:0] lane;
  logic       tick;
  logic       bps_en;

  logic accept, edge_det, bit_smp, stop_ok, stop_bad, timeout;

  // Two-flop synchroniser for the asynchronous line, idling high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx_pin_in;
      rxs   <= sync1;
    end
  end

  // Bit timing restarts at every detected start edge; samples land mid-bit.
  assign bps_en = (state == START) || (state == DATA) || (state == STOP);

  rx_bps_module #(
    .DIV (BIT_DIV)
  ) u_bps (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (edge_det),
    .en    (bps_en),
    .half  (1'b1),
    .tick  (tick)
  );

`ifdef RX_TIMEOUT_EN
  localparam int TO_LIMIT = RX_TIMEOUT_BITS * BIT_DIV;
  localparam int TW       = $clog2(TO_LIMIT);

  logic [TW-1:0] to_cnt;
  logic          got_byte;
  logic          to_hit;

  assign to_hit = (to_cnt == TW'(TO_LIMIT - 1));

  // Counts continuous idle-high cycles in WAIT once a byte of this frame has arrived.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt   <= '0;
      got_byte <= 1'b0;
    end else begin
      if (accept) begin
        got_byte <= 1'b0;
      end else if (stop_ok) begin
        got_byte <= 1'b1;
      end
      if ((state == WAIT) && rxs && got_byte && !to_hit) begin
        to_cnt <= to_cnt + 1'b1;
      end else begin
        to_cnt <= '0;
      end
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    edge_det  = 1'b0;
    bit_smp   = 1'b0;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_en && (len != 5'd0)) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (!rxs) begin
          edge_det  = 1'b1;
          state_nxt = START;
        end
`ifdef RX_TIMEOUT_EN
        else if (got_byte && to_hit) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
      START: begin
        // A line that is high again at mid-start was a glitch: rearm silently.
        if (tick) begin
          state_nxt = rxs ? WAIT : DATA;
        end
      end
      DATA: begin
        if (tick) begin
          bit_smp = 1'b1;
          if (bitcnt == 4'd7) begin
            state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (rxs) begin
            stop_ok   = 1'b1;
            state_nxt = (cnt == 5'd1) ? DONE : WAIT;
          end else begin
            stop_bad  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Remaining byte count doubles as the lane index: first byte goes highest.
  assign lane = 4'(cnt - 5'd1);

  // Frame datapath: byte assembly, lane writes and the output pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data <= '0;
      rx_done <= 1'b0;
      rx_err  <= 1'b0;
      cnt     <= '0;
      bitcnt  <= '0;
      shreg   <= '0;
    end else begin
      rx_done <= (state == DONE);
      rx_err  <= stop_bad | timeout;
      if (accept) begin
        rx_data <= '0;
        cnt     <= (len > MAX_LEN) ? MAX_LEN : len;
      end
      if (edge_det) begin
        bitcnt <= '0;
      end
      if (bit_smp) begin
        shreg  <= {rxs, shreg[7:1]};
        bitcnt <= bitcnt + 4'd1;
      end
      if (stop_ok) begin
        rx_data[{lane, 3'b000} +: 8] <= shreg;
        cnt <= cnt - 5'd1;
      end
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_rx_frame_module.sv
// Scoreboard bench for rx_frame_module at BIT_DIV = 16.
// Latency: expected rx_done 156 cycles after the final start bit is driven on the pin.
// Backpressure: none; stimulus waits for the scoreboard queue to drain between frames.
module tb_rx_frame_module;

  logic         clk;
  logic         rst_n;
  logic         rx_pin_in;
  logic         rx_en;
  logic [4:0]   len;
  logic [127:0] rx_data;
  logic         rx_done;
  logic         rx_err;
  logic         rx_busy;

  typedef struct {
    bit           is_err;
    logic [127:0] data;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   start_cyc = 0;

  rx_frame_module #(
    .CLK_HZ    (160),
    .BAUD      (10),
    .MAX_BYTES (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_pin_in (rx_pin_in),
    .rx_en     (rx_en),
    .len       (len),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_err    (rx_err),
    .rx_busy   (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input bit is_err, input logic [127:0] data, input int lat);
    exp_t e;
    e.is_err = is_err;
    e.data   = data;
    e.lat    = lat;
    exp_q.push_back(e);
  endtask

  task automatic arm(input logic [4:0] l);
    @(negedge clk);
    rx_en = 1'b1;
    len   = l;
    @(negedge clk);
    rx_en = 1'b0;
    chk1("busy_rise", rx_busy, 1'b1);
    repeat (5) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx_pin_in = 1'b0;
    start_cyc = cyc;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_pin_in = b[i];
      repeat (16) @(negedge clk);
    end
    rx_pin_in = stop_bit;
    repeat (16) @(negedge clk);
    rx_pin_in = 1'b1;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: %0d outputs pending, expected 0", nm, exp_q.size());
      exp_q.delete();
    end
    repeat (20) @(negedge clk);
  endtask

  // Monitor: every done/err pulse is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (rx_done || rx_err)) begin
        chk1("done_err_exclusive", rx_done && rx_err, 1'b0);
        chk1("busy_low_at_end", rx_busy, 1'b0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: done=%b err=%b data=%h, expected no output", rx_done, rx_err, rx_data);
        end else begin
          e = exp_q.pop_front();
          chk1("err_flag", rx_err, e.is_err);
          chk("frame_data", rx_data, e.data);
          if (e.lat >= 0) chki("latency", cyc - start_cyc, e.lat);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    rx_pin_in = 1'b1;
    rx_en     = 1'b0;
    len       = 5'd0;
    repeat (3) @(negedge clk);
    chk("reset_data", rx_data, 128'h0);
    chk1("reset_done", rx_done, 1'b0);
    chk1("reset_err", rx_err, 1'b0);
    chk1("reset_busy", rx_busy, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte, with end-to-end latency.
    push(1'b0, 128'hA5, 156);
    arm(5'd1);
    send_byte(8'hA5, 1'b1);
    wait_idle("len1");

    // Three bytes; an rx_en mid-frame must be dropped.
    push(1'b0, 128'h112233, 156);
    arm(5'd3);
    send_byte(8'h11, 1'b1);
    @(negedge clk);
    rx_en = 1'b1;
    len   = 5'd1;
    @(negedge clk);
    rx_en = 1'b0;
    chk1("busy_while_busy", rx_busy, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    wait_idle("len3");

    // Full 16-byte frame, then len 20 clamped to 16.
    for (int pass = 0; pass < 2; pass++) begin
      push(1'b0, 128'h000102030405060708090a0b0c0d0e0f, 156);
      arm((pass == 0) ? 5'd16 : 5'd20);
      for (int b = 0; b < 16; b++) send_byte(8'(b), 1'b1);
      wait_idle("len16");
    end

    // len 0 is ignored and leaves the previous frame in place.
    @(negedge clk);
    rx_en = 1'b1;
    len   = 5'd0;
    @(negedge clk);
    rx_en = 1'b0;
    chk1("len0_busy", rx_busy, 1'b0);
    chk("len0_data_hold", rx_data, 128'h000102030405060708090a0b0c0d0e0f);
    repeat (10) @(negedge clk);

    // Short glitch before a real frame.
    push(1'b0, 128'h5A, 156);
    arm(5'd1);
    rx_pin_in = 1'b0;
    repeat (4) @(negedge clk);
    rx_pin_in = 1'b1;
    repeat (40) @(negedge clk);
    chk1("glitch_busy", rx_busy, 1'b1);
    send_byte(8'h5A, 1'b1);
    wait_idle("glitch");

    // Bad stop bit on the second byte.
    push(1'b1, 128'h7700, 155);
    arm(5'd2);
    send_byte(8'h77, 1'b1);
    send_byte(8'h99, 1'b0);
    wait_idle("stop_err");
    chk("stop_err_hold", rx_data, 128'h7700);

    // Reset in the middle of the data bits.
    arm(5'd1);
    rx_pin_in = 1'b0;
    repeat (16) @(negedge clk);
    rx_pin_in = 1'b1;
    repeat (24) @(negedge clk);
    chk1("pre_reset_busy", rx_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("midreset_busy", rx_busy, 1'b0);
    chk1("midreset_done", rx_done, 1'b0);
    chk1("midreset_err", rx_err, 1'b0);
    chk("midreset_data", rx_data, 128'h0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    push(1'b0, 128'hC3, 156);
    arm(5'd1);
    send_byte(8'hC3, 1'b1);
    wait_idle("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
